if_id_queue: RTL and testbench

Instruction queue between the fetch stage and the decode stage of the lapido core. Each fetched instruction is stored together with its next PC in a small FIFO, and the FIFO hands them to decode with a valid/ready handshake. This decouples fetch from decode stalls. A flush input drops every queued entry when a branch is taken or a jump resolves, so that wrong-path instructions are discarded.

---
 rtl/if_id_queue.sv | 100 ++++++++++
 tb/tb_if_id_queue.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - fetch-to-decode instruction queue with flush.
// Optional combinational empty-queue bypass is enabled by defining IFQ_BYPASS_EN.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

module if_id_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = `PC_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if_valid,
    input  logic [31:0]              if_instruction,
    input  logic [PC_W-1:0]          if_next_pc,
    output logic                     if_ready,
    output logic                     id_valid,
    output logic [31:0]              id_instruction,
    output logic [PC_W-1:0]          id_next_pc,
    input  logic                     id_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]     instr_mem [DEPTH];
    logic [PC_W-1:0] pc_mem    [DEPTH];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty, full, bypass, wr_en, rd_en;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == FULL_CNT);
        if_ready = !full;
`ifdef IFQ_BYPASS_EN
        bypass   = empty && !flush;
`else
        bypass   = 1'b0;
`endif
        // Head outputs are masked while empty so storage never needs a reset.
        if (bypass) begin
            id_valid       = if_valid;
            id_instruction = if_instruction;
            id_next_pc     = if_next_pc;
        end else if (empty) begin
            id_valid       = 1'b0;
            id_instruction = '0;
            id_next_pc     = '0;
        end else begin
            id_valid       = 1'b1;
            id_instruction = instr_mem[rd_ptr_q];
            id_next_pc     = pc_mem[rd_ptr_q];
        end

        // A bypassed word taken by decode the same cycle never touches storage.
        wr_en = if_valid && !full && !(bypass && id_ready);
        rd_en = id_valid && id_ready && !bypass;

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (rst || flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(wr_en) - CW'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst && !flush) begin
            instr_mem[wr_ptr_q] <= if_instruction;
            pc_mem[wr_ptr_q]    <= if_next_pc;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - randomized self-checking bench for if_id_queue against a queue model.
module tb_if_id_queue;

    localparam int DEPTH = 4;
    localparam int PC_W  = 16;

    logic              clk;
    logic              rst;
    logic              if_valid;
    logic [31:0]       if_instruction;
    logic [PC_W-1:0]   if_next_pc;
    logic              if_ready;
    logic              id_valid;
    logic [31:0]       id_instruction;
    logic [PC_W-1:0]   id_next_pc;
    logic              id_ready;
    logic              flush;
    logic [2:0]        count;

    if_id_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_instruction(if_instruction), .if_next_pc(if_next_pc),
        .if_ready(if_ready),
        .id_valid(id_valid), .id_instruction(id_instruction), .id_next_pc(id_next_pc),
        .id_ready(id_ready), .flush(flush), .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [31:0]     ins;
        logic [PC_W-1:0] pc;
    } ent_t;

    ent_t mq[$];
    int   total = 0;
    int   bad   = 0;

    logic            obs_valid, obs_ready;
    logic [2:0]      obs_count;
    logic [31:0]     obs_instr;
    logic [PC_W-1:0] obs_pc;
    logic            exp_valid, exp_ready;
    logic [2:0]      exp_count;
    logic [31:0]     exp_instr;
    logic [PC_W-1:0] exp_pc;
    logic            obs_pop;
    logic            seen_aa;

`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // Drive one cycle, sample mid-cycle, then advance the reference model at the edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [PC_W-1:0] pc,
                        input logic r, input logic fl, input logic rs);
        int  sz;
        bit  byp_now, acc, pop;
        if_valid       = v;
        if_instruction = ins;
        if_next_pc     = pc;
        id_ready       = r;
        flush          = fl;
        rst            = rs;
        @(negedge clk);
        sz      = mq.size();
        byp_now = BYP && (sz == 0) && !fl;
        exp_ready = (sz != DEPTH);
        exp_count = 3'(sz);
        if (byp_now) begin
            exp_valid = v;
            exp_instr = ins;
            exp_pc    = pc;
        end else if (sz == 0) begin
            exp_valid = 1'b0;
            exp_instr = '0;
            exp_pc    = '0;
        end else begin
            exp_valid = 1'b1;
            exp_instr = mq[0].ins;
            exp_pc    = mq[0].pc;
        end
        obs_valid = id_valid;
        obs_ready = if_ready;
        obs_count = count;
        obs_instr = id_instruction;
        obs_pc    = id_next_pc;
        obs_pop   = id_valid && r;
        if (id_valid === 1'b1 && id_instruction === 32'hAAAA_AAAA) seen_aa = 1'b1;
        @(posedge clk);
        if (rs || fl) begin
            mq.delete();
        end else begin
            acc = v && (sz != DEPTH);
            pop = exp_valid && r;
            if (byp_now) begin
                if (acc && !r) mq.push_back('{ins, pc});
            end else begin
                if (pop) void'(mq.pop_front());
                if (acc) mq.push_back('{ins, pc});
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(0, 32'h0, '0, 0, 0, 1);
        step(0, 32'h0, '0, 0, 0, 1);
        step(0, 32'hDEAD_BEEF, 16'h1234, 1, 0, 0);
        total++;
        if (obs_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", obs_count); end
        total++;
        if (obs_valid !== 1'b0) begin bad++; $display("FAIL reset_id_valid got=%b exp=0", obs_valid); end
        total++;
        if (obs_ready !== 1'b1) begin bad++; $display("FAIL reset_if_ready got=%b exp=1", obs_ready); end
        total++;
        if (obs_instr !== 32'h0 || obs_pc !== '0) begin
            bad++; $display("FAIL reset_head got=%h/%h exp=0/0", obs_instr, obs_pc);
        end
    endtask

    task automatic test_fill();
        for (int k = 1; k <= 4; k++) begin
            step(1, 32'h1111_1111 * k, PC_W'(k), 0, 0, 0);
            total++;
            if (obs_count !== exp_count) begin bad++; $display("FAIL fill_count got=%0d exp=%0d", obs_count, exp_count); end
        end
        step(1, 32'h5555_5555, 16'd5, 0, 0, 0);
        total++;
        if (obs_count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", obs_count); end
        total++;
        if (obs_ready !== 1'b0) begin bad++; $display("FAIL full_if_ready got=%b exp=0", obs_ready); end
    endtask

    task automatic test_drain();
        for (int k = 1; k <= 4; k++) begin
            step(0, 32'h0, '0, 1, 0, 0);
            total++;
            if (obs_valid !== 1'b1 || obs_instr !== 32'h1111_1111 * k || obs_pc !== PC_W'(k)) begin
                bad++; $display("FAIL drain_%0d got=%b/%h/%h exp=1/%h/%h", k, obs_valid, obs_instr, obs_pc,
                                32'h1111_1111 * k, PC_W'(k));
            end
        end
        step(0, 32'h0, '0, 0, 0, 0);
        total++;
        if (obs_count !== 3'd0 || obs_instr !== 32'h0) begin
            bad++; $display("FAIL drain_empty got=%0d/%h exp=0/0", obs_count, obs_instr);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got[$];
        for (int k = 0; k < 10; k++) begin
            step(1, 32'hD000_0000 + 32'(k), PC_W'(100 + k), 1, 0, 0);
            if (obs_pop) got.push_back(obs_instr);
            if (k > 0) begin
                total++;
                if (obs_count !== (BYP ? 3'd0 : 3'd1) || obs_valid !== 1'b1) begin
                    bad++; $display("FAIL stream_count got=%0d/%b exp=%0d/1", obs_count, obs_valid, BYP ? 0 : 1);
                end
            end
        end
        step(0, 32'h0, '0, 1, 0, 0);
        if (obs_pop) got.push_back(obs_instr);
        total++;
        if (got.size() !== 10) begin bad++; $display("FAIL stream_len got=%0d exp=10", got.size()); end
        for (int k = 0; k < got.size(); k++) begin
            total++;
            if (got[k] !== 32'hD000_0000 + 32'(k)) begin
                bad++; $display("FAIL stream_order got=%h exp=%h", got[k], 32'hD000_0000 + 32'(k));
            end
        end
    endtask

    task automatic test_flush();
        seen_aa = 1'b0;
        for (int k = 0; k < 3; k++) step(1, 32'hF000_0000 + 32'(k), PC_W'(k), 0, 0, 0);
        step(1, 32'hAAAA_AAAA, 16'hAA, 1, 1, 0);
        step(0, 32'h0, '0, 0, 0, 0);
        total++;
        if (obs_count !== 3'd0 || obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
            bad++; $display("FAIL flush_clear got=%0d/%b/%b exp=0/0/1", obs_count, obs_valid, obs_ready);
        end
        step(1, 32'hC0C0_C0C0, 16'd7, 0, 0, 0);
        step(0, 32'h0, '0, 1, 0, 0);
        total++;
        if (obs_valid !== 1'b1 || obs_instr !== 32'hC0C0_C0C0 || obs_pc !== 16'd7) begin
            bad++; $display("FAIL flush_next got=%b/%h/%h exp=1/c0c0c0c0/0007", obs_valid, obs_instr, obs_pc);
        end
        total++;
        if (seen_aa !== 1'b0) begin bad++; $display("FAIL flush_dropped got=%b exp=0", seen_aa); end
    endtask

    task automatic test_reset_mid();
        step(1, 32'h7777_0001, 16'd1, 0, 0, 0);
        step(1, 32'h7777_0002, 16'd2, 0, 0, 0);
        total++;
        if (obs_count !== 3'd1) begin bad++; $display("FAIL mid_pre_count got=%0d exp=1", obs_count); end
        step(1, 32'h7777_0003, 16'd3, 1, 1, 1);
        step(0, 32'h0, '0, 0, 0, 0);
        total++;
        if (obs_count !== 3'd0 || obs_pc !== '0) begin
            bad++; $display("FAIL mid_reset got=%0d/%h exp=0/0", obs_count, obs_pc);
        end
        step(1, 32'hBBBB_BBBB, 16'd9, 0, 0, 0);
        step(0, 32'h0, '0, 1, 0, 0);
        total++;
        if (obs_valid !== 1'b1 || obs_instr !== 32'hBBBB_BBBB || obs_pc !== 16'd9) begin
            bad++; $display("FAIL mid_next got=%b/%h/%h exp=1/bbbbbbbb/0009", obs_valid, obs_instr, obs_pc);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom, PC_W'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 63) == 0));
            total++;
            if ({obs_valid, obs_ready, obs_count, obs_instr, obs_pc} !==
                {exp_valid, exp_ready, exp_count, exp_instr, exp_pc}) begin
                bad++;
                $display("FAIL random_%0d got=%b/%b/%0d/%h/%h exp=%b/%b/%0d/%h/%h", k,
                         obs_valid, obs_ready, obs_count, obs_instr, obs_pc,
                         exp_valid, exp_ready, exp_count, exp_instr, exp_pc);
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
        if_instruction = '0; if_next_pc = '0; seen_aa = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
